// File: rtl/half_adder.sv
// Single-bit half adder with a registered result, valid flag
// and saturating operation / carry counters.
module half_adder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             in_valid,
   output logic             sum,
   output logic             carry,
   output logic             sum_q,
   output logic             carry_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] carry_count
);

   logic             sum_d;
   logic             carry_d;
   logic             valid_q;
   logic             valid_d;
   logic [CNT_W-1:0] op_cnt_q;
   logic [CNT_W-1:0] op_cnt_d;
   logic [CNT_W-1:0] cy_cnt_q;
   logic [CNT_W-1:0] cy_cnt_d;
   logic             sum_r_q;
   logic             carry_r_q;
   logic             op_sat;
   logic             cy_sat;

   // Combinational core, independent of clock, reset and valid.
   always_comb begin
      sum   = a ^ b;
      carry = a & b;
   end

   // Next state: capture on in_valid, counters stick at all-ones.
   always_comb begin
      op_sat   = &op_cnt_q;
      cy_sat   = &cy_cnt_q;
      sum_d    = sum_r_q;
      carry_d  = carry_r_q;
      valid_d  = in_valid;
      op_cnt_d = op_cnt_q;
      cy_cnt_d = cy_cnt_q;
      if (in_valid) begin
         sum_d   = sum;
         carry_d = carry;
         if (!op_sat) begin
            op_cnt_d = op_cnt_q + 1'b1;
         end
         if (carry && !cy_sat) begin
            cy_cnt_d = cy_cnt_q + 1'b1;
         end
      end
   end

   // Registered state, cleared immediately by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r_q   <= 1'b0;
         carry_r_q <= 1'b0;
         valid_q   <= 1'b0;
         op_cnt_q  <= '0;
         cy_cnt_q  <= '0;
      end else begin
         sum_r_q   <= sum_d;
         carry_r_q <= carry_d;
         valid_q   <= valid_d;
         op_cnt_q  <= op_cnt_d;
         cy_cnt_q  <= cy_cnt_d;
      end
   end

   assign sum_q       = sum_r_q;
   assign carry_q     = carry_r_q;
   assign out_valid   = valid_q;
   assign op_count    = op_cnt_q;
   assign carry_count = cy_cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a CNT_W=2 instance for saturation
// and a default-width instance sharing the same stimulus.
module tb_half_adder;

   logic        clk;
   logic        rst;
   logic        a;
   logic        b;
   logic        in_valid;
   logic        sum_n, carry_n, sum_q_n, carry_q_n, ov_n;
   logic [1:0]  opc_n, cyc_n;
   logic        sum_w, carry_w, sum_q_w, carry_q_w, ov_w;
   logic [15:0] opc_w, cyc_w;

   int n_cmp = 0;
   int n_bad = 0;

   half_adder #(.CNT_W(2)) u_narrow (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
      .sum(sum_n), .carry(carry_n), .sum_q(sum_q_n),
      .carry_q(carry_q_n), .out_valid(ov_n),
      .op_count(opc_n), .carry_count(cyc_n)
   );

   half_adder u_wide (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
      .sum(sum_w), .carry(carry_w), .sum_q(sum_q_w),
      .carry_q(carry_q_w), .out_valid(ov_w),
      .op_count(opc_w), .carry_count(cyc_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded budget");
      $fatal(1);
   end

   task automatic test_reset();
      logic [6:0]  got_n;
      logic [34:0] got_w;
      #3;
      got_n = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
      got_w = {sum_q_w, carry_q_w, ov_w, opc_w, cyc_w};
      n_cmp++;
      if (got_n !== 7'd0) begin
         n_bad++;
         $display("FAIL reset_narrow: got %h want 0", got_n);
      end
      n_cmp++;
      if (got_w !== 35'd0) begin
         n_bad++;
         $display("FAIL reset_wide: got %h want 0", got_w);
      end
   endtask

   task automatic test_comb(input string tag);
      logic [3:0] exp_s;
      logic [3:0] exp_c;
      logic [3:0] got;
      exp_s = 4'b0110;
      exp_c = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         a = i[1];
         b = i[0];
         #1;
         got = {sum_n, carry_n, sum_w, carry_w};
         n_cmp++;
         if (got !== {exp_s[i], exp_c[i], exp_s[i], exp_c[i]}) begin
            n_bad++;
            $display("FAIL comb_%s ab=%0d: got %b want %b", tag, i,
                     got, {exp_s[i], exp_c[i], exp_s[i], exp_c[i]});
         end
      end
   endtask

   task automatic test_latency();
      logic [6:0] got;
      @(negedge clk);
      a = 1'b1; b = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      got = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
      n_cmp++;
      if (got !== 7'b0_1_1_01_01) begin
         n_bad++;
         $display("FAIL latency_capture: got %b want 0110101", got);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      got = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
      n_cmp++;
      if (got !== 7'b0_1_0_01_01) begin
         n_bad++;
         $display("FAIL latency_drop: got %b want 0100101", got);
      end
   endtask

   task automatic test_hold();
      logic [6:0] got;
      @(negedge clk);
      a = 1'b0; b = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         got = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
         n_cmp++;
         if (got !== 7'b0_1_0_01_01) begin
            n_bad++;
            $display("FAIL hold_%0d: got %b want 0100101", i, got);
         end
      end
   endtask

   task automatic test_saturation();
      logic [6:0]  got_n;
      logic [6:0]  exp_n;
      logic [31:0] got_w;
      logic [31:0] exp_w;
      logic [1:0]  en;
      int          ew;
      int          ec;
      en = 2'd1;
      ew = 1;
      ec = 1;
      @(negedge clk);
      a = 1'b1; b = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (en != 2'd3) en = en + 2'd1;
         ew++;
         ec++;
         exp_n = {1'b0, 1'b1, 1'b1, en, en};
         got_n = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
         n_cmp++;
         if (got_n !== exp_n) begin
            n_bad++;
            $display("FAIL sat11_%0d: got %b want %b", i, got_n, exp_n);
         end
         exp_w = {ew[15:0], ec[15:0]};
         got_w = {opc_w, cyc_w};
         n_cmp++;
         if (got_w !== exp_w) begin
            n_bad++;
            $display("FAIL wide11_%0d: got %h want %h", i, got_w, exp_w);
         end
      end
      @(negedge clk);
      a = 1'b0; b = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         ew++;
         got_n = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
         n_cmp++;
         if (got_n !== 7'b1_0_1_11_11) begin
            n_bad++;
            $display("FAIL sat01_%0d: got %b want 1011111", i, got_n);
         end
         exp_w = {ew[15:0], ec[15:0]};
         got_w = {opc_w, cyc_w};
         n_cmp++;
         if (got_w !== exp_w) begin
            n_bad++;
            $display("FAIL wide01_%0d: got %h want %h", i, got_w, exp_w);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [6:0]  got_n;
      logic [34:0] got_w;
      @(negedge clk);
      a = 1'b1; b = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({ov_n, ov_w} !== 2'b11) begin
         n_bad++;
         $display("FAIL arst_pre: got %b want 11", {ov_n, ov_w});
      end
      #2;
      rst = 1'b1;
      #1;
      got_n = {sum_q_n, carry_q_n, ov_n, opc_n, cyc_n};
      got_w = {sum_q_w, carry_q_w, ov_w, opc_w, cyc_w};
      n_cmp++;
      if (got_n !== 7'd0) begin
         n_bad++;
         $display("FAIL arst_narrow: got %b want 0", got_n);
      end
      n_cmp++;
      if (got_w !== 35'd0) begin
         n_bad++;
         $display("FAIL arst_wide: got %h want 0", got_w);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset_dominance();
      logic [4:0] got;
      @(negedge clk);
      rst = 1'b1;
      a = 1'b1; b = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         got = {ov_n, opc_n, cyc_n};
         n_cmp++;
         if (got !== 5'd0 || opc_w !== 16'd0) begin
            n_bad++;
            $display("FAIL rstdom_%0d: got %b/%0d want 0/0", i,
                     got, opc_w);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      got = {ov_n, opc_n, cyc_n};
      n_cmp++;
      if (got !== 5'b1_01_01 || {opc_w, cyc_w} !== {16'd1, 16'd1}) begin
         n_bad++;
         $display("FAIL rstdom_first: got %b/%0d/%0d want 10101/1/1",
                  got, opc_w, cyc_w);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a = 1'b0;
      b = 1'b0;
      in_valid = 1'b0;
      test_reset();
      test_comb("rst1");
      @(negedge clk);
      rst = 1'b0;
      test_comb("rst0");
      test_latency();
      test_hold();
      test_saturation();
      test_async_reset();
      test_reset_dominance();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
